// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, flag bundle and sequencing states for alu_pipe.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MUL  = 4'b1010
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier, one multiplier bit per cycle, low WIDTH bits kept.
// product is the final value combinationally during the done cycle, then held.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;

  assign busy     = (cnt != '0);
  assign done     = (cnt == CNT_W'(1));
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign product  = busy ? acc_next : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CNT_W'(WIDTH);
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked integer ALU with registered result and flags.
// Build option ALU_MUL_EN adds the sequential multiplier for op 1010.
//
// state | meaning
// IDLE  | accepting ops; single-cycle ops load the output register directly
// BUSY  | multiplier iterating, input stalled
// DONE  | product ready, waiting for the output register to free up
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             illegal_op
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int MSB     = WIDTH - 1;

  logic [WIDTH-1:0]   op_res;
  logic               op_illegal;
  logic               op_carry;
  logic               op_ovf;
  alu_flags_t         op_flags;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = operand_b[SHAMT_W-1:0];
  assign add_w = {1'b0, operand_a} + {1'b0, operand_b};
  // Top bit of the widened difference is the borrow.
  assign sub_w = {1'b0, operand_a} - {1'b0, operand_b};

  always_comb begin
    op_res     = '0;
    op_illegal = 1'b0;
    op_carry   = 1'b0;
    op_ovf     = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        op_res   = add_w[WIDTH-1:0];
        op_carry = add_w[WIDTH];
        op_ovf   = (operand_a[MSB] == operand_b[MSB]) && (add_w[MSB] != operand_a[MSB]);
      end
      OP_SUB: begin
        op_res   = sub_w[WIDTH-1:0];
        op_carry = ~sub_w[WIDTH];
        op_ovf   = (operand_a[MSB] != operand_b[MSB]) && (sub_w[MSB] != operand_a[MSB]);
      end
      OP_AND:  op_res = operand_a & operand_b;
      OP_OR:   op_res = operand_a | operand_b;
      OP_XOR:  op_res = operand_a ^ operand_b;
      OP_SLL:  op_res = operand_a << shamt;
      OP_SRL:  op_res = operand_a >> shamt;
      OP_SRA:  op_res = WIDTH'($signed(operand_a) >>> shamt);
      OP_SLT:  op_res = WIDTH'($signed(operand_a) < $signed(operand_b));
      OP_SLTU: op_res = WIDTH'(operand_a < operand_b);
`ifdef ALU_MUL_EN
      OP_MUL:  op_res = '0;
`endif
      default: op_illegal = 1'b1;
    endcase
  end

  assign op_flags = '{zero: (op_res == '0), neg: op_res[MSB], carry: op_carry, ovf: op_ovf};

  alu_state_e       state;
  logic             out_free;
  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic             load_alu;
  logic             load_mul;
  logic [WIDTH-1:0] mul_product;
  alu_flags_t       mul_flags;
  alu_flags_t       flags_q;

  assign out_free  = !out_valid || out_ready;
  assign mul_flags = '{zero: (mul_product == '0), neg: mul_product[MSB], carry: 1'b0, ovf: 1'b0};

`ifdef ALU_MUL_EN
  alu_state_e state_next;
  logic       mul_busy;

  assign is_mul = (alu_ctrl == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (operand_a),
    .b       (operand_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (mul_start) state_next = BUSY;
      BUSY: begin
        if (mul_done)       state_next = out_free ? IDLE : DONE;
        else if (!mul_busy) state_next = IDLE;
      end
      DONE: if (out_free) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
`else
  assign state       = IDLE;
  assign is_mul      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  always_comb begin
    in_ready  = (state == IDLE) && out_free;
    accept    = in_valid && in_ready;
    mul_start = accept && is_mul;
    load_alu  = accept && !is_mul;
    load_mul  = (((state == BUSY) && mul_done) || (state == DONE)) && out_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      flags_q    <= '0;
      illegal_op <= 1'b0;
    end else if (load_alu) begin
      out_valid  <= 1'b1;
      alu_result <= op_res;
      flags_q    <= op_flags;
      illegal_op <= op_illegal;
    end else if (load_mul) begin
      out_valid  <= 1'b1;
      alu_result <= mul_product;
      flags_q    <= mul_flags;
      illegal_op <= 1'b0;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  assign zero_flag  = flags_q.zero;
  assign neg_flag   = flags_q.neg;
  assign carry_flag = flags_q.carry;
  assign ovf_flag   = flags_q.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed corner cases plus randomized traffic against an arithmetic reference model.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int SW = $clog2(W);
  typedef logic [W+4:0] txn_t;

  localparam longint SMAX = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint SMIN = -(64'sd1 <<< (W - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic [3:0]   alu_ctrl = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] alu_result;
  logic         zero_flag, neg_flag, carry_flag, ovf_flag, illegal_op;
  txn_t         obs;

  int   n_vec = 0;
  int   n_err = 0;
  txn_t q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .alu_ctrl   (alu_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .zero_flag  (zero_flag),
    .neg_flag   (neg_flag),
    .carry_flag (carry_flag),
    .ovf_flag   (ovf_flag),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  assign obs = {illegal_op, ovf_flag, carry_flag, neg_flag, zero_flag, alu_result};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Packed as {illegal, ovf, carry, neg, zero, result}.
  function automatic txn_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       sa, sb, sr;
    logic [63:0]  ua, ub, ur;
    logic [W-1:0] r;
    logic         c, v, ill;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
    case (op)
      4'd0: begin
        ur = ua + ub; r = ur[W-1:0]; c = (ur > 64'hFFFF_FFFF);
        sr = sa + sb; v = (sr > SMAX) || (sr < SMIN);
      end
      4'd1: begin
        ur = ua - ub; r = ur[W-1:0]; c = (a >= b);
        sr = sa - sb; v = (sr > SMAX) || (sr < SMIN);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin ur = ua << b[SW-1:0]; r = ur[W-1:0]; end
      4'd6: r = a >> b[SW-1:0];
      4'd7: begin sr = sa >>> b[SW-1:0]; r = sr[W-1:0]; end
      4'd8: r = (sa < sb) ? 1 : 0;
      4'd9: r = (a < b) ? 1 : 0;
`ifdef ALU_MUL_EN
      4'd10: begin ur = ua * ub; r = ur[W-1:0]; end
`endif
      default: ill = 1'b1;
    endcase
    return {ill, v, c, r[W-1], (r == '0), r};
  endfunction

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  // Called one time unit after a rising edge; leaves one unit after the output edge.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input txn_t exp, input int exp_lat);
    int   lat;
    logic rdy_leak;
    operand_a = a; operand_b = b; alu_ctrl = op; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_leak = 1'b0;
    while (!out_valid && lat < 40) begin
      rdy_leak |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_ready_while_busy"}, rdy_leak, 0);
    check({tag, "_out"}, obs, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    txn_t exp;
    txn_t exp1, exp2;
    logic held, stray;
    int   mul_lat;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", obs, 0);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_ovf",  4'd0, 32'h7FFF_FFFF, 32'h0000_0001, {5'b01010, 32'h8000_0000}, 1);
    do_op("sub_eq",   4'd1, 32'd5,         32'd5,         {5'b00101, 32'h0000_0000}, 1);
    do_op("sub_wrap", 4'd1, 32'd0,         32'd1,         {5'b00010, 32'hFFFF_FFFF}, 1);
    do_op("sra_31",   4'd7, 32'h8000_0000, 32'h0000_003F, {5'b00010, 32'hFFFF_FFFF}, 1);
    do_op("slt_neg",  4'd8, 32'hFFFF_FFFF, 32'd1,         {5'b00000, 32'h0000_0001}, 1);
    do_op("sltu_big", 4'd9, 32'hFFFF_FFFF, 32'd1,         {5'b00001, 32'h0000_0000}, 1);
    do_op("illegal_f", 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, {5'b10001, 32'h0000_0000}, 1);
`ifdef ALU_MUL_EN
    mul_lat = 32;
    exp = {5'b00010, 32'hFFFE_0001};
`else
    mul_lat = 1;
    exp = {5'b10001, 32'h0000_0000};
`endif
    do_op("mul_ffff", 4'hA, 32'h0000_FFFF, 32'h0000_FFFF, exp, mul_lat);
    @(posedge clk); #1;

    // Backpressure: ADD sits in the output register while XOR waits at the input.
    exp1 = {5'b00000, 32'h2345_6789};
    exp2 = {5'b00010, 32'hFF00_FF00};
    out_ready = 1'b0; in_valid = 1'b1; alu_ctrl = 4'd0;
    operand_a = 32'h1234_5678; operand_b = 32'h1111_1111;
    #1;
    check("bp_first_ready", in_ready, 1);
    @(posedge clk); #1;
    alu_ctrl = 4'd4; operand_a = 32'hF0F0_F0F0; operand_b = 32'h0FF0_0FF0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall_ready", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_value", obs, exp1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_valid", out_valid, 1);
    check("bp_second_value", obs, exp2);
    @(posedge clk); #1;
    check("bp_drained", out_valid, 0);

    // Reset during multiply iteration.
    in_valid = 1'b1; alu_ctrl = 4'hA; operand_a = 32'h0000_FFFF; operand_b = 32'h0000_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_outputs", obs, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", in_ready, 1);
    stray = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      stray |= out_valid;
    end
    check("rst_no_stray", stray, 0);

    // Randomized traffic with random backpressure, scoreboarded in order.
    held = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!held) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        alu_ctrl  = 4'($urandom_range(0, 15));
        operand_a = pick_val();
        operand_b = pick_val();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rnd_spurious_out", out_valid, 0);
        else begin
          exp = q.pop_front();
          check("rnd_out", obs, exp);
        end
      end
      if (in_valid && in_ready) q.push_back(model(alu_ctrl, operand_a, operand_b));
      held = in_valid && !in_ready;
      @(posedge clk); #1;
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && q.size() > 0; i++) begin
      #1;
      if (out_valid) begin
        exp = q.pop_front();
        check("drain_out", obs, exp);
      end
      @(posedge clk); #1;
    end
    check("drain_empty", q.size(), 0);
    #1;
    check("drain_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
